ps2_key_decoder: RTL

- Upstream stage of the display top: receives raw PS/2 keyboard frames in the 100 MHz `clk` domain and hands decoded key events to `pixel_gen` and `seven_segment`.
- Synchronises and filters the PS/2 lines, shifts in 11-bit frames, checks framing and parity, and interprets the E0 (extended) and F0 (break) prefixes.
- Outputs a one-cycle key-event strobe plus level "held" flags for the four arrow keys.

---
 rtl/ps2_key_decoder_if.sv | 22 ++
 rtl/ps2_key_decoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder_if.sv
// Decoded key-event bus from ps2_key_decoder (master) to its display consumers (slave).
interface ps2_key_decoder_if;
    logic [7:0] code;
    logic       code_valid;
    logic       is_break;
    logic       is_ext;
    logic       frame_err;
    logic       key_up;
    logic       key_down;
    logic       key_left;
    logic       key_right;

    modport master (
        output code, code_valid, is_break, is_ext, frame_err,
               key_up, key_down, key_left, key_right
    );

    modport slave (
        input code, code_valid, is_break, is_ext, frame_err,
              key_up, key_down, key_left, key_right
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: line conditioning, 11-bit framing, E0/F0 prefix decode, arrow-key held flags.
// Optional REPEAT_FILTER_EN suppresses typematic repeats of the last make code.
module ps2_key_decoder #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    ps2_key_decoder_if.master kev
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    // Index 0 is the clock line, index 1 the data line.
    logic [1:0]    sync1, sync2, filt;
    logic [FW-1:0] fcnt [2];
    logic          filt_clk_q;
    logic          sample;
    logic          data_s;

    // NOTE: conditioning flops reset to 1 so a reset never fabricates a clock fall on an idle bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= '1;
            sync2      <= '1;
            filt       <= '1;
            filt_clk_q <= 1'b1;
            for (int i = 0; i < 2; i++) fcnt[i] <= '0;
        end else begin
            sync1      <= {ps2_data, ps2_clk};
            sync2      <= sync1;
            filt_clk_q <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    assign sample = filt_clk_q & ~filt[0];
    assign data_s = filt[1];

    state_t        state, state_nx;
    logic [3:0]    bitcnt;
    logic [9:0]    shreg;   // {stop, parity, data[7:0]} once full
    logic [TW-1:0] tcnt;
    logic          timeout, byte_ok, err_nx;

    assign timeout = (tcnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx = state;
        byte_ok  = 1'b0;
        err_nx   = 1'b0;
        unique case (state)
            IDLE:  if (sample && !data_s) state_nx = RECV;
            RECV: begin
                if (sample) begin
                    if (bitcnt == 4'd10) state_nx = CHECK;
                end else if (timeout) begin
                    state_nx = IDLE;
                    err_nx   = 1'b1;
                end
            end
            CHECK: begin
                state_nx = IDLE;
                if (shreg[9] && (^shreg[8:0])) byte_ok = 1'b1;
                else                           err_nx  = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bitcnt <= '0;
            shreg  <= '0;
            tcnt   <= '0;
        end else if (state == IDLE) begin
            bitcnt <= 4'd1;
            tcnt   <= '0;
        end else if (state == RECV) begin
            if (sample) begin
                shreg  <= {data_s, shreg[9:1]};
                bitcnt <= bitcnt + 1'b1;
                tcnt   <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    logic [7:0] rx_byte, code_q;
    logic       key_event, suppress;
    logic       valid_q, brk_q, ext_q, err_q;
    logic       ext_pend, brk_pend;
    logic [3:0] arrows;     // {up, down, left, right}

    assign rx_byte   = shreg[7:0];
    assign key_event = byte_ok && (rx_byte != 8'hE0) && (rx_byte != 8'hF0);

`ifdef REPEAT_FILTER_EN
    logic       last_vld;
    logic [8:0] last_make;  // {is_ext, code} of the most recent make event

    assign suppress = !brk_pend && last_vld && (last_make == {ext_pend, rx_byte});

    always_ff @(posedge clk) begin
        if (reset) begin
            last_vld  <= 1'b0;
            last_make <= '0;
        end else if (key_event) begin
            if (brk_pend) begin
                last_vld <= 1'b0;
            end else begin
                last_vld  <= 1'b1;
                last_make <= {ext_pend, rx_byte};
            end
        end
    end
`else
    assign suppress = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            code_q   <= '0;
            valid_q  <= 1'b0;
            brk_q    <= 1'b0;
            ext_q    <= 1'b0;
            err_q    <= 1'b0;
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            arrows   <= '0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= err_nx;
            if (err_nx) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end else if (byte_ok && rx_byte == 8'hE0) begin
                ext_pend <= 1'b1;
            end else if (byte_ok && rx_byte == 8'hF0) begin
                brk_pend <= 1'b1;
            end else if (key_event) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
                if (!suppress) begin
                    valid_q <= 1'b1;
                    code_q  <= rx_byte;
                    brk_q   <= brk_pend;
                    ext_q   <= ext_pend;
                end
                // Keypad codes share these values; only extended ones move the flags.
                if (ext_pend) begin
                    case (rx_byte)
                        8'h75:   arrows[3] <= ~brk_pend;
                        8'h72:   arrows[2] <= ~brk_pend;
                        8'h6B:   arrows[1] <= ~brk_pend;
                        8'h74:   arrows[0] <= ~brk_pend;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign kev.code       = code_q;
    assign kev.code_valid = valid_q;
    assign kev.is_break   = brk_q;
    assign kev.is_ext     = ext_q;
    assign kev.frame_err  = err_q;
    assign kev.key_up     = arrows[3];
    assign kev.key_down   = arrows[2];
    assign kev.key_left   = arrows[1];
    assign kev.key_right  = arrows[0];
endmodule
